// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage
//  Purpose  : RV32I decode stage with ID/EX pipeline register.
//             Produces a one-hot ALU control word and both ALU operands.
//  Revision : 1.0 - initial release
// ============================================================================
module id_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_Valid_1,
   output logic        o_Ready_1,
   input  logic [31:0] i_PC_32,
   input  logic [31:0] i_Inst_32,
   output logic [4:0]  o_Rs1Addr_5,
   output logic [4:0]  o_Rs2Addr_5,
   input  logic [31:0] i_Rs1Data_32,
   input  logic [31:0] i_Rs2Data_32,
   input  logic        i_Flush_1,
   output logic        o_Valid_1,
   input  logic        i_Ready_1,
   output logic [31:0] o_PC_32,
   output logic [31:0] o_Inst_32,
   output logic [11:0] o_ALUControl_12,
   output logic [31:0] o_ALUOperand1_32,
   output logic [31:0] o_ALUOperand2_32,
   output logic [31:0] o_StoreData_32,
   output logic [4:0]  o_RdAddr_5,
   output logic        o_RegWrite_1,
   output logic        o_MemRead_1,
   output logic        o_MemWrite_1,
   output logic        o_Branch_1,
   output logic        o_Jump_1,
   output logic        o_IllegalInst_1
);

   localparam logic [6:0] c_opc_op     = 7'h33;
   localparam logic [6:0] c_opc_op_imm = 7'h13;
   localparam logic [6:0] c_opc_load   = 7'h03;
   localparam logic [6:0] c_opc_store  = 7'h23;
   localparam logic [6:0] c_opc_lui    = 7'h37;
   localparam logic [6:0] c_opc_auipc  = 7'h17;
   localparam logic [6:0] c_opc_jal    = 7'h6F;
   localparam logic [6:0] c_opc_jalr   = 7'h67;
   localparam logic [6:0] c_opc_branch = 7'h63;
   localparam logic [6:0] c_opc_misc   = 7'h0F;
   localparam logic [6:0] c_opc_system = 7'h73;

   localparam logic [11:0] c_alu_add  = 12'h800;
   localparam logic [11:0] c_alu_pc4  = 12'h400;
   localparam logic [11:0] c_alu_sub  = 12'h200;
   localparam logic [11:0] c_alu_slt  = 12'h100;
   localparam logic [11:0] c_alu_sltu = 12'h080;
   localparam logic [11:0] c_alu_and  = 12'h040;
   localparam logic [11:0] c_alu_or   = 12'h020;
   localparam logic [11:0] c_alu_xor  = 12'h010;
   localparam logic [11:0] c_alu_sll  = 12'h008;
   localparam logic [11:0] c_alu_srl  = 12'h004;
   localparam logic [11:0] c_alu_sra  = 12'h002;
   localparam logic [11:0] c_alu_lui  = 12'h001;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [11:0] ctrl;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] store;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        illegal;
   } idex_t;

   // alt selects SUB over ADD and SRA over SRL
   function automatic logic [11:0] alu_sel(input logic [2:0] f3, input logic alt);
      logic [11:0] sel;
      case (f3)
         3'b000:  sel = alt ? c_alu_sub : c_alu_add;
         3'b001:  sel = c_alu_sll;
         3'b010:  sel = c_alu_slt;
         3'b011:  sel = c_alu_sltu;
         3'b100:  sel = c_alu_xor;
         3'b101:  sel = alt ? c_alu_sra : c_alu_srl;
         3'b110:  sel = c_alu_or;
         default: sel = c_alu_and;
      endcase
      return sel;
   endfunction

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;
   logic [31:0] shamt;

   assign opcode = i_Inst_32[6:0];
   assign rd     = i_Inst_32[11:7];
   assign funct3 = i_Inst_32[14:12];
   assign funct7 = i_Inst_32[31:25];

   assign imm_i = {{20{i_Inst_32[31]}}, i_Inst_32[31:20]};
   assign imm_s = {{20{i_Inst_32[31]}}, i_Inst_32[31:25], i_Inst_32[11:7]};
   assign imm_b = {{19{i_Inst_32[31]}}, i_Inst_32[31], i_Inst_32[7],
                   i_Inst_32[30:25], i_Inst_32[11:8], 1'b0};
   assign imm_u = {i_Inst_32[31:12], 12'b0};
   assign imm_j = {{11{i_Inst_32[31]}}, i_Inst_32[31], i_Inst_32[19:12],
                   i_Inst_32[20], i_Inst_32[30:21], 1'b0};
   assign shamt = {27'b0, i_Inst_32[24:20]};

   assign o_Rs1Addr_5 = i_Inst_32[19:15];
   assign o_Rs2Addr_5 = i_Inst_32[24:20];

   idex_t dec;

   always_comb begin
      dec           = '0;
      dec.pc        = i_PC_32;
      dec.inst      = i_Inst_32;
      dec.store     = i_Rs2Data_32;
      dec.rd        = rd;
      case (opcode)
         c_opc_op: begin
            dec.op1       = i_Rs1Data_32;
            dec.op2       = i_Rs2Data_32;
            dec.reg_write = 1'b1;
            if (funct7 == 7'h00) begin
               dec.ctrl = alu_sel(funct3, 1'b0);
            end else if (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
               dec.ctrl = alu_sel(funct3, 1'b1);
            end else begin
               dec.op1       = '0;
               dec.op2       = '0;
               dec.reg_write = 1'b0;
               dec.illegal   = 1'b1;
            end
         end
         c_opc_op_imm: begin
            dec.op1       = i_Rs1Data_32;
            dec.reg_write = 1'b1;
            dec.ctrl      = alu_sel(funct3, (funct3 == 3'b101) & funct7[5]);
            dec.op2       = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt : imm_i;
         end
         c_opc_load: begin
            dec.ctrl      = c_alu_add;
            dec.op1       = i_Rs1Data_32;
            dec.op2       = imm_i;
            dec.mem_read  = 1'b1;
            dec.reg_write = 1'b1;
         end
         c_opc_store: begin
            dec.ctrl      = c_alu_add;
            dec.op1       = i_Rs1Data_32;
            dec.op2       = imm_s;
            dec.mem_write = 1'b1;
         end
         c_opc_lui: begin
            dec.ctrl      = c_alu_lui;
            dec.op2       = imm_u;
            dec.reg_write = 1'b1;
         end
         c_opc_auipc: begin
            dec.ctrl      = c_alu_add;
            dec.op1       = i_PC_32;
            dec.op2       = imm_u;
            dec.reg_write = 1'b1;
         end
         // Adder forms the jump target; the PC4 path supplies the link value
         c_opc_jal: begin
            dec.ctrl      = c_alu_pc4;
            dec.op1       = i_PC_32;
            dec.op2       = imm_j;
            dec.jump      = 1'b1;
            dec.reg_write = 1'b1;
         end
         c_opc_jalr: begin
            dec.ctrl      = c_alu_pc4;
            dec.op1       = i_Rs1Data_32;
            dec.op2       = imm_i;
            dec.jump      = 1'b1;
            dec.reg_write = 1'b1;
         end
         c_opc_branch: begin
            dec.op1    = i_PC_32;
            dec.op2    = imm_b;
            dec.branch = 1'b1;
         end
         c_opc_misc, c_opc_system: begin
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
      if (rd == 5'd0) begin
         dec.reg_write = 1'b0;
      end
   end

   logic  valid_q;
   logic  valid_d;
   idex_t payload_q;
   idex_t payload_d;
   logic  accept;

   assign o_Ready_1 = ~valid_q | i_Ready_1;
   assign accept    = i_Valid_1 & o_Ready_1 & ~i_Flush_1;

   always_comb begin
      valid_d   = valid_q;
      payload_d = payload_q;
      if (i_Flush_1) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d   = 1'b1;
         payload_d = dec;
      end else if (valid_q & i_Ready_1) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
      end
   end

   assign o_Valid_1        = valid_q;
   assign o_PC_32          = payload_q.pc;
   assign o_Inst_32        = payload_q.inst;
   assign o_ALUControl_12  = payload_q.ctrl;
   assign o_ALUOperand1_32 = payload_q.op1;
   assign o_ALUOperand2_32 = payload_q.op2;
   assign o_StoreData_32   = payload_q.store;
   assign o_RdAddr_5       = payload_q.rd;
   assign o_RegWrite_1     = payload_q.reg_write;
   assign o_MemRead_1      = payload_q.mem_read;
   assign o_MemWrite_1     = payload_q.mem_write;
   assign o_Branch_1       = payload_q.branch;
   assign o_Jump_1         = payload_q.jump;
   assign o_IllegalInst_1  = payload_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_stage
//  Purpose  : Self-checking bench for id_stage (vector table + scoreboard).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage;

   logic        clk;
   logic        rst;
   logic        i_Valid_1;
   logic        o_Ready_1;
   logic [31:0] i_PC_32;
   logic [31:0] i_Inst_32;
   logic [4:0]  o_Rs1Addr_5;
   logic [4:0]  o_Rs2Addr_5;
   logic [31:0] i_Rs1Data_32;
   logic [31:0] i_Rs2Data_32;
   logic        i_Flush_1;
   logic        o_Valid_1;
   logic        i_Ready_1;
   logic [31:0] o_PC_32;
   logic [31:0] o_Inst_32;
   logic [11:0] o_ALUControl_12;
   logic [31:0] o_ALUOperand1_32;
   logic [31:0] o_ALUOperand2_32;
   logic [31:0] o_StoreData_32;
   logic [4:0]  o_RdAddr_5;
   logic        o_RegWrite_1;
   logic        o_MemRead_1;
   logic        o_MemWrite_1;
   logic        o_Branch_1;
   logic        o_Jump_1;
   logic        o_IllegalInst_1;

   id_stage dut (
      .clk              (clk),
      .rst              (rst),
      .i_Valid_1        (i_Valid_1),
      .o_Ready_1        (o_Ready_1),
      .i_PC_32          (i_PC_32),
      .i_Inst_32        (i_Inst_32),
      .o_Rs1Addr_5      (o_Rs1Addr_5),
      .o_Rs2Addr_5      (o_Rs2Addr_5),
      .i_Rs1Data_32     (i_Rs1Data_32),
      .i_Rs2Data_32     (i_Rs2Data_32),
      .i_Flush_1        (i_Flush_1),
      .o_Valid_1        (o_Valid_1),
      .i_Ready_1        (i_Ready_1),
      .o_PC_32          (o_PC_32),
      .o_Inst_32        (o_Inst_32),
      .o_ALUControl_12  (o_ALUControl_12),
      .o_ALUOperand1_32 (o_ALUOperand1_32),
      .o_ALUOperand2_32 (o_ALUOperand2_32),
      .o_StoreData_32   (o_StoreData_32),
      .o_RdAddr_5       (o_RdAddr_5),
      .o_RegWrite_1     (o_RegWrite_1),
      .o_MemRead_1      (o_MemRead_1),
      .o_MemWrite_1     (o_MemWrite_1),
      .o_Branch_1       (o_Branch_1),
      .o_Jump_1         (o_Jump_1),
      .o_IllegalInst_1  (o_IllegalInst_1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // flags = {RegWrite, MemRead, MemWrite, Branch, Jump, Illegal}
   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] rs1d;
      logic [31:0] rs2d;
      logic [11:0] ctrl;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd;
      logic [5:0]  flags;
      bit          chk_ops;
   } vec_t;

   localparam int c_nv = 16;
   vec_t vecs [c_nv];
   vec_t sb [$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] rs1d, input logic [31:0] rs2d,
                               input logic [11:0] ctrl, input logic [31:0] op1,
                               input logic [31:0] op2, input logic [4:0] rd,
                               input logic [5:0] flags, input bit chk_ops);
      vec_t v;
      v.inst = inst; v.pc = pc; v.rs1d = rs1d; v.rs2d = rs2d; v.ctrl = ctrl;
      v.op1 = op1; v.op2 = op2; v.rd = rd; v.flags = flags; v.chk_ops = chk_ops;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      i_Valid_1    = 1'b1;
      i_Inst_32    = v.inst;
      i_PC_32      = v.pc;
      i_Rs1Data_32 = v.rs1d;
      i_Rs2Data_32 = v.rs2d;
   endtask

   function automatic logic [5:0] out_flags();
      return {o_RegWrite_1, o_MemRead_1, o_MemWrite_1, o_Branch_1, o_Jump_1, o_IllegalInst_1};
   endfunction

   // Scoreboard: every consumed output must match the oldest accepted instruction
   always @(negedge clk) begin
      if (!rst && o_Valid_1 && i_Ready_1) begin
         if (sb.size() == 0) begin
            chk("unexpected_output_valid", {31'b0, o_Valid_1}, 32'd0);
         end else begin
            vec_t e;
            e = sb.pop_front();
            chk("sb_inst",  o_Inst_32, e.inst);
            chk("sb_pc",    o_PC_32, e.pc);
            chk("sb_ctrl",  {20'b0, o_ALUControl_12}, {20'b0, e.ctrl});
            chk("sb_rd",    {27'b0, o_RdAddr_5}, {27'b0, e.rd});
            chk("sb_flags", {26'b0, out_flags()}, {26'b0, e.flags});
            chk("sb_store", o_StoreData_32, e.rs2d);
            if (e.chk_ops) begin
               chk("sb_op1", o_ALUOperand1_32, e.op1);
               chk("sb_op2", o_ALUOperand2_32, e.op2);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = mk(32'h00500093, 32'h000, 32'h0,        32'h0,        12'h800, 32'h0,        32'h5,        5'd1,  6'b100000, 1); // addi x1,x0,5
      vecs[1]  = mk(32'h12345137, 32'h004, 32'h11,       32'h22,       12'h001, 32'h0,        32'h12345000, 5'd2,  6'b100000, 1); // lui
      vecs[2]  = mk(32'h402081B3, 32'h008, 32'h10,       32'h3,        12'h200, 32'h10,       32'h3,        5'd3,  6'b100000, 1); // sub
      vecs[3]  = mk(32'h008000EF, 32'h100, 32'h0,        32'h0,        12'h400, 32'h100,      32'h8,        5'd1,  6'b100010, 1); // jal
      vecs[4]  = mk(32'hFFC32283, 32'h104, 32'h1000,     32'h0,        12'h800, 32'h1000,     32'hFFFFFFFC, 5'd5,  6'b110000, 1); // lw
      vecs[5]  = mk(32'h00732423, 32'h108, 32'h2000,     32'hDEADBEEF, 12'h800, 32'h2000,     32'h8,        5'd8,  6'b001000, 1); // sw
      vecs[6]  = mk(32'hFE208CE3, 32'h200, 32'h1,        32'h55,       12'h000, 32'h200,      32'hFFFFFFF8, 5'd25, 6'b000100, 1); // beq -8
      vecs[7]  = mk(32'h00001217, 32'h300, 32'h0,        32'h0,        12'h800, 32'h300,      32'h1000,     5'd4,  6'b100000, 1); // auipc
      vecs[8]  = mk(32'h004280E7, 32'h400, 32'h4000,     32'h0,        12'h400, 32'h4000,     32'h4,        5'd1,  6'b100010, 1); // jalr
      vecs[9]  = mk(32'h4033D313, 32'h404, 32'h80000000, 32'h0,        12'h002, 32'h80000000, 32'h3,        5'd6,  6'b100000, 1); // srai
      vecs[10] = mk(32'hFFF4A413, 32'h408, 32'h5,        32'h0,        12'h100, 32'h5,        32'hFFFFFFFF, 5'd8,  6'b100000, 1); // slti -1
      vecs[11] = mk(32'h00C5C533, 32'h40C, 32'hF0F0,     32'h0FF0,     12'h010, 32'hF0F0,     32'h0FF0,     5'd10, 6'b100000, 1); // xor
      vecs[12] = mk(32'hFFFFFFFF, 32'h410, 32'h7,        32'h9,        12'h000, 32'h0,        32'h0,        5'd31, 6'b000001, 0); // illegal
      vecs[13] = mk(32'h00100013, 32'h414, 32'h0,        32'h0,        12'h800, 32'h0,        32'h1,        5'd0,  6'b000000, 1); // addi x0
      vecs[14] = mk(32'h022080B3, 32'h418, 32'h1,        32'h2,        12'h000, 32'h0,        32'h0,        5'd1,  6'b000001, 0); // bad funct7
      vecs[15] = mk(32'h0FF0000F, 32'h41C, 32'h0,        32'h0,        12'h000, 32'h0,        32'h0,        5'd0,  6'b000000, 0); // fence

      rst = 1'b1; i_Valid_1 = 1'b0; i_PC_32 = '0; i_Inst_32 = '0;
      i_Rs1Data_32 = '0; i_Rs2Data_32 = '0; i_Flush_1 = 1'b0; i_Ready_1 = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("rst_valid", {31'b0, o_Valid_1}, 32'd0);
      chk("rst_ready", {31'b0, o_Ready_1}, 32'd1);
      chk("rst_ctrl",  {20'b0, o_ALUControl_12}, 32'd0);
      chk("rst_op1",   o_ALUOperand1_32, 32'd0);
      chk("rst_op2",   o_ALUOperand2_32, 32'd0);
      chk("rst_flags", {26'b0, out_flags()}, 32'd0);

      // Back-to-back stream at full throughput
      for (int i = 0; i < c_nv; i++) begin
         @(posedge clk); #1;
         apply(vecs[i]);
         sb.push_back(vecs[i]);
         @(negedge clk);
         chk("rs1_addr", {27'b0, o_Rs1Addr_5}, {27'b0, vecs[i].inst[19:15]});
         chk("rs2_addr", {27'b0, o_Rs2Addr_5}, {27'b0, vecs[i].inst[24:20]});
      end
      @(posedge clk); #1 i_Valid_1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Backpressure: A held for 3 cycles while B waits
      i_Ready_1 = 1'b0;
      apply(vecs[0]);
      sb.push_back(vecs[0]);
      @(posedge clk); #1;
      apply(vecs[2]);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_ready", {31'b0, o_Ready_1}, 32'd0);
         chk("bp_valid", {31'b0, o_Valid_1}, 32'd1);
         chk("bp_inst",  o_Inst_32, vecs[0].inst);
         chk("bp_op2",   o_ALUOperand2_32, vecs[0].op2);
         @(posedge clk); #1;
      end
      i_Ready_1 = 1'b1;
      sb.push_back(vecs[2]);
      @(posedge clk); #1;
      i_Valid_1 = 1'b0;
      @(negedge clk);
      chk("bp_second_inst", o_Inst_32, vecs[2].inst);
      @(posedge clk); #1;

      // Flush kills both the held and the offered instruction
      i_Ready_1 = 1'b0;
      apply(vecs[3]);
      @(posedge clk); #1;
      apply(vecs[4]);
      i_Flush_1 = 1'b1;
      @(negedge clk);
      chk("flush_pre_valid", {31'b0, o_Valid_1}, 32'd1);
      @(posedge clk); #1;
      i_Flush_1 = 1'b0; i_Valid_1 = 1'b0;
      @(negedge clk);
      chk("flush_valid", {31'b0, o_Valid_1}, 32'd0);
      i_Ready_1 = 1'b1;
      @(negedge clk);
      chk("flush_valid_later", {31'b0, o_Valid_1}, 32'd0);

      // Reset mid-stream
      @(posedge clk); #1;
      i_Ready_1 = 1'b0;
      apply(vecs[5]);
      @(posedge clk); #1;
      rst = 1'b1;
      apply(vecs[6]);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mrst_valid", {31'b0, o_Valid_1}, 32'd0);
      chk("mrst_pc",    o_PC_32, 32'd0);
      chk("mrst_inst",  o_Inst_32, 32'd0);
      chk("mrst_ctrl",  {20'b0, o_ALUControl_12}, 32'd0);
      chk("mrst_op1",   o_ALUOperand1_32, 32'd0);
      chk("mrst_store", o_StoreData_32, 32'd0);
      chk("mrst_flags", {26'b0, out_flags()}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; i_Valid_1 = 1'b0; i_Ready_1 = 1'b1;
      repeat (2) @(negedge clk);
      chk("mrst_valid_after", {31'b0, o_Valid_1}, 32'd0);
      chk("sb_empty", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/id_stage.md
# id_stage

Decode stage of the RV32I core, sitting between fetch and the ALU. It accepts one fetched instruction per cycle over a valid/ready handshake and reads rs1 and rs2 from the register file. It then produces the one-hot 12-bit ALU control word plus both ALU operands, and holds them in an ID/EX pipeline register with backpressure and flush.

## Interface
- No parameters.
- clk  in  1  rising-edge clock, single domain.
- rst  in  1  synchronous, active-high reset.
- i_Valid_1  in  1  fetch presents an instruction.
- o_Ready_1  out  1  stage can accept; o_Ready_1 = ~o_Valid_1 | i_Ready_1.
- i_PC_32  in  32  instruction address.
- i_Inst_32  in  32  instruction word.
- o_Rs1Addr_5, o_Rs2Addr_5  out  5  combinational from i_Inst_32 [19:15] and [24:20].
- i_Rs1Data_32, i_Rs2Data_32  in  32  combinational register-file read data. Write-through bypass is the register file's job.
- i_Flush_1  in  1  kill the held instruction and the one being offered.
- o_Valid_1  out  1  ID/EX register holds an instruction.
- i_Ready_1  in  1  execute consumes it.
- o_PC_32, o_Inst_32  out  32  registered copies.
- o_ALUControl_12  out  12  one-hot, bits [11:0] = {ADD, PC4, SUB, SLT, SLTU, AND, OR, XOR, SLL, SRL, SRA, LUI}.
- o_ALUOperand1_32, o_ALUOperand2_32  out  32  ALU operands.
- o_StoreData_32  out  32  registered rs2 data.
- o_RdAddr_5  out  5  destination register.
- o_RegWrite_1, o_MemRead_1, o_MemWrite_1, o_Branch_1, o_Jump_1, o_IllegalInst_1  out  1  control flags.

## Operation
- Accept condition: i_Valid_1 & o_Ready_1 & ~i_Flush_1. On accept, every decoded field is loaded into the register and o_Valid_1 is set to 1.
- If o_Valid_1 & i_Ready_1 holds without an accept, o_Valid_1 goes to 0.
- When o_Valid_1 & ~i_Ready_1, all outputs are held bit-stable.
- Immediates are sign-extended per RV32I I/S/B/U/J formats. Shift-immediate operand2 = {27'b0, shamt}.
- Decode by opcode, giving (control, op1, op2, flags):
  - OP (0x33): op1 = rs1, op2 = rs2. funct3/funct7 select ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND. RegWrite.
  - OP-IMM (0x13): op1 = rs1, op2 = immI. No SUB; funct7[5] selects SRA vs SRL. RegWrite.
  - LOAD (0x03): ADD, rs1 + immI, MemRead, RegWrite.
  - STORE (0x23): ADD, rs1 + immS, MemWrite, StoreData = rs2.
  - LUI (0x37): LUI, op2 = immU, RegWrite.
  - AUIPC (0x17): ADD, PC + immU, RegWrite.
  - JAL (0x6F): PC4, PC + immJ, Jump, RegWrite. The ALU adder path supplies the target and the PC4 path supplies the link value.
  - JALR (0x67): PC4, rs1 + immJ-format not used; operands are rs1 + immI. Jump, RegWrite.
  - BRANCH (0x63): control = 0, PC + immB, Branch. StoreData = rs2 so execute can compare.
  - MISC-MEM/SYSTEM (0x0F/0x73): NOP, with control 0 and all flags 0.
- Any other opcode, or an illegal funct7 on OP: control 0, all flags 0, o_IllegalInst_1 = 1. The instruction still passes downstream as valid.
- If rd = x0, o_RegWrite_1 is forced to 0.
- Exactly one control bit is set, or none.

## Timing
- Reset: o_Valid_1 = 0 and every registered output = 0. Because o_Valid_1 = 0, o_Ready_1 = 1 in the first cycle after reset.
- Latency is one cycle: an instruction accepted at edge N is visible from edge N until consumed.
- Throughput is one instruction per cycle when i_Ready_1 is held high. Accept and consume in the same cycle replaces the register contents.
- Flush: in a cycle where i_Flush_1 = 1, the offered instruction is dropped. o_Valid_1 = 0 after the edge, regardless of i_Ready_1.
- Flush has priority over accept, and reset has priority over flush.
- Reset asserted mid-stream: the register empties at the next edge and no instruction survives.
- o_Rs*Addr_5 are not registered. Register-file data is sampled at the accept edge.

## Test plan
- addi x1,x0,5 (0x00500093), PC 0x0, rs1 data 0 → one cycle later: o_Valid_1 = 1, control 0x800, op1 0, op2 5, rd 1, RegWrite 1.
- lui x2,0x12345 (0x12345137) → control 0x001, op2 0x12345000, RegWrite 1. Then sub x3,x1,x2 (0x402081B3) back-to-back → control 0x200, op1/op2 = supplied rs1/rs2 data.
- jal x1,+8 (0x008000EF) at PC 0x100 → control 0x400, op1 0x100, op2 8, Jump 1, RegWrite 1.
- Backpressure: i_Ready_1 = 0 for 3 cycles with a second instruction offered → o_Ready_1 = 0, outputs unchanged; the second instruction is accepted on the cycle i_Ready_1 returns to 1.
- i_Flush_1 = 1 with o_Valid_1 = 1 and i_Valid_1 = 1 → o_Valid_1 = 0 next cycle, both instructions lost. Reset mid-stream → all outputs 0.
- 0xFFFFFFFF → o_IllegalInst_1 = 1, control 0, RegWrite/MemRead/MemWrite 0. addi x0,x0,1 → RegWrite 0.
